// File: rtl/mac_feeder.sv
// mac_feeder: streams activation/weight beats into the left and top edges of a
// ROWS x COLS systolic MAC array. Row lane i delays its beat by 1+i cycles and
// column lane j by 1+j cycles. After the last beat, the lanes drain for
// max(ROWS,COLS) cycles. A one-cycle counter_sync_out pulse then marks the tile end.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   start, k_len          tile start request and beat count (captured on start)
//   in_valid / in_ready   input beat handshake
//   in_act, in_wgt        one activation per row, one weight per column
//   act_data, act_valid   skewed activations (left edge)
//   wgt_data, wgt_valid   skewed weights (top edge)
//   counter_sync_out      tile-end pulse to the array
//   busy                  feeder is not idle
//   stall_cnt             only when MAC_FEEDER_STALL_CNT_EN is defined:
//                         counts STREAM cycles without an input beat
//
// State table:
//   IDLE   | waiting for start with non-zero k_len
//   STREAM | accepting beats until k_len have been taken
//   DRAIN  | pushing bubbles until the last beat leaves the longest lane
//   SYNC   | single cycle, counter_sync_out asserted
module mac_feeder #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int KLEN_W = 8
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                start,
    input  logic [KLEN_W-1:0]                   k_len,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic signed [ROWS-1:0][DATA_W-1:0]  in_act,
    input  logic signed [COLS-1:0][DATA_W-1:0]  in_wgt,
    output logic signed [ROWS-1:0][DATA_W-1:0]  act_data,
    output logic [ROWS-1:0]                     act_valid,
    output logic signed [COLS-1:0][DATA_W-1:0]  wgt_data,
    output logic [COLS-1:0]                     wgt_valid,
    output logic                                counter_sync_out,
    output logic                                busy
`ifdef MAC_FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]                         stall_cnt
`endif
);

    localparam int DRAIN_LEN = (ROWS > COLS) ? ROWS : COLS;
    localparam int DCNT_W    = $clog2(DRAIN_LEN + 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, SYNC} state_t;

    state_t             state, next_state;
    logic [KLEN_W-1:0]  k_lat;
    logic [KLEN_W-1:0]  beat_cnt;
    logic [DCNT_W-1:0]  drain_cnt;
    logic               accept;
    logic               tile_start;

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        case (state)
            IDLE:   if (start && (k_len != '0)) next_state = STREAM;
            STREAM: begin
                in_ready = 1'b1;
                if (in_valid && (beat_cnt == k_lat - 1'b1)) next_state = DRAIN;
            end
            DRAIN:  if (drain_cnt == '0) next_state = SYNC;
            SYNC:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign accept     = in_valid && (state == STREAM);
    assign tile_start = (state == IDLE) && (next_state == STREAM);

    // busy and counter_sync_out are flopped from next_state so they line up
    // with the state register without a decode after the flop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= IDLE;
            busy             <= 1'b0;
            counter_sync_out <= 1'b0;
            k_lat            <= '0;
            beat_cnt         <= '0;
            drain_cnt        <= '0;
        end else begin
            state            <= next_state;
            busy             <= (next_state != IDLE);
            counter_sync_out <= (next_state == SYNC);
            if (tile_start) begin
                k_lat    <= k_len;
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if ((state == STREAM) && (next_state == DRAIN))
                drain_cnt <= DCNT_W'(DRAIN_LEN - 1);
            else if ((state == DRAIN) && (drain_cnt != '0))
                drain_cnt <= drain_cnt - 1'b1;
        end
    end

    // Each lane is a shift register of exactly 1+lane stages. Bubbles enter
    // with zero data, so invalid outputs are always zero.
    for (genvar i = 0; i < ROWS; i++) begin : g_row
        logic [DATA_W-1:0] d_q [0:i];
        logic              v_q [0:i];
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                for (int s = 0; s <= i; s++) begin
                    d_q[s] <= '0;
                    v_q[s] <= 1'b0;
                end
            end else begin
                d_q[0] <= accept ? in_act[i] : '0;
                v_q[0] <= accept;
                for (int s = 1; s <= i; s++) begin
                    d_q[s] <= d_q[s-1];
                    v_q[s] <= v_q[s-1];
                end
            end
        end
        assign act_data[i]  = d_q[i];
        assign act_valid[i] = v_q[i];
    end

    for (genvar j = 0; j < COLS; j++) begin : g_col
        logic [DATA_W-1:0] d_q [0:j];
        logic              v_q [0:j];
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                for (int s = 0; s <= j; s++) begin
                    d_q[s] <= '0;
                    v_q[s] <= 1'b0;
                end
            end else begin
                d_q[0] <= accept ? in_wgt[j] : '0;
                v_q[0] <= accept;
                for (int s = 1; s <= j; s++) begin
                    d_q[s] <= d_q[s-1];
                    v_q[s] <= v_q[s-1];
                end
            end
        end
        assign wgt_data[j]  = d_q[j];
        assign wgt_valid[j] = v_q[j];
    end

`ifdef MAC_FEEDER_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n)
            stall_cnt <= '0;
        else if (tile_start)
            stall_cnt <= '0;
        else if ((state == STREAM) && !in_valid && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_mac_feeder.sv
module tb_mac_feeder;

   logic                  clk;
   logic                  reset_n;
   logic                  start;
   logic [7:0]            k_len;
   logic                  in_valid;
   logic                  in_ready;
   logic [7:0][7:0]       in_act;
   logic [7:0][7:0]       in_wgt;
   logic [7:0][7:0]       act_data;
   logic [7:0]            act_valid;
   logic [7:0][7:0]       wgt_data;
   logic [7:0]            wgt_valid;
   logic                  counter_sync_out;
   logic                  busy;
`ifdef MAC_FEEDER_STALL_CNT_EN
   logic [15:0]           stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   mac_feeder dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .start            (start),
      .k_len            (k_len),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_act           (in_act),
      .in_wgt           (in_wgt),
      .act_data         (act_data),
      .act_valid        (act_valid),
      .wgt_data         (wgt_data),
      .wgt_valid        (wgt_valid),
      .counter_sync_out (counter_sync_out),
      .busy             (busy)
`ifdef MAC_FEEDER_STALL_CNT_EN
      ,
      .stall_cnt        (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Beat b carries b*16+lane on every activation and weight lane.
   task automatic set_beat(input int b);
      for (int i = 0; i < 8; i++) begin
         in_act[i] = 8'(b * 16 + i);
         in_wgt[i] = 8'(b * 16 + i);
      end
   endtask

   task automatic wait_sync(input int limit, output int n);
      n = 0;
      while (!counter_sync_out && n < limit) begin
         tick();
         n++;
      end
   endtask

   logic [7:0][7:0] exp_act;
   logic [7:0][7:0] exp_wgt;
   int n_wait;
   int accepted;
   int v0_cnt;
   int sync_cnt;

   initial begin
      reset_n  = 1'b0;
      start    = 1'b0;
      k_len    = 8'd0;
      in_valid = 1'b0;
      in_act   = '0;
      in_wgt   = '0;
      tick();
      tick();

      // Reset state
      chk("rst_busy", busy, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_sync", counter_sync_out, 1'b0);
      chk("rst_act_valid", act_valid, 8'h00);
      chk("rst_wgt_valid", wgt_valid, 8'h00);
      chk("rst_act_data", act_data, 64'h0);
      chk("rst_wgt_data", wgt_data, 64'h0);
      reset_n = 1'b1;
      tick();

      // Single beat, act[i]=i+1, wgt[j]=10+j, valid held
      for (int i = 0; i < 8; i++) begin
         in_act[i] = 8'(i + 1);
         in_wgt[i] = 8'(10 + i);
      end
      in_valid = 1'b1;
      start    = 1'b1;
      k_len    = 8'd1;
      tick();
      start = 1'b0;
      chk("t1_busy", busy, 1'b1);
      chk("t1_in_ready", in_ready, 1'b1);
      for (int n = 1; n <= 8; n++) begin
         tick();
         exp_act = '0;
         exp_wgt = '0;
         exp_act[n-1] = 8'(n);
         exp_wgt[n-1] = 8'(10 + n - 1);
         chk("t1_act_valid", act_valid, 8'(8'h01 << (n - 1)));
         chk("t1_wgt_valid", wgt_valid, 8'(8'h01 << (n - 1)));
         chk("t1_act_data", act_data, exp_act);
         chk("t1_wgt_data", wgt_data, exp_wgt);
         chk("t1_no_sync", counter_sync_out, 1'b0);
         if (n == 1) chk("t1_in_ready_drain", in_ready, 1'b0);
         if (n == 4) chk("t1_act3", act_data[3], 8'd4);
         if (n == 8) chk("t1_wgt7", wgt_data[7], 8'd17);
      end
      tick();
      chk("t1_sync", counter_sync_out, 1'b1);
      chk("t1_sync_busy", busy, 1'b1);
      tick();
      chk("t1_sync_end", counter_sync_out, 1'b0);
      chk("t1_idle_busy", busy, 1'b0);
      in_valid = 1'b0;

      // k_len=4 with a bubble between beats 1 and 2
      start = 1'b1;
      k_len = 8'd4;
      tick();
      start = 1'b0;
      set_beat(1);
      in_valid = 1'b1;
      tick();
      chk("t2_e1_valid", act_valid, 8'h01);
      chk("t2_e1_act0", act_data[0], 8'h10);
      in_valid = 1'b0;
      in_act   = '1;
      in_wgt   = '1;
      tick();
      chk("t2_e2_valid", act_valid, 8'h02);
      chk("t2_e2_act0", act_data[0], 8'h00);
      chk("t2_e2_wgt0", wgt_data[0], 8'h00);
      chk("t2_e2_in_ready", in_ready, 1'b1);
      in_valid = 1'b1;
      set_beat(2);
      tick();
      set_beat(3);
      tick();
      set_beat(4);
      tick();
      in_valid = 1'b0;
      chk("t2_e5_in_ready", in_ready, 1'b0);
      chk("t2_e5_busy", busy, 1'b1);
      chk("t2_e5_act_valid", act_valid, 8'h17);
      chk("t2_e5_wgt_valid", wgt_valid, 8'h17);
      chk("t2_e5_act0", act_data[0], 8'h40);
      chk("t2_e5_act3", act_data[3], 8'h00);
      tick();
      tick();
      tick();
      chk("t2_e8_act_valid", act_valid, 8'hB8);
      chk("t2_e8_act6", act_data[6], 8'h00);
      chk("t2_e8_act7", act_data[7], 8'h17);
      chk("t2_e8_wgt7", wgt_data[7], 8'h17);
`ifdef MAC_FEEDER_STALL_CNT_EN
      chk("t2_stall_cnt", stall_cnt, 16'd1);
`endif
      wait_sync(20, n_wait);
      chk("t2_sync_delay", n_wait, 5);
      tick();
      chk("t2_idle", busy, 1'b0);

      // start with k_len=0 is ignored
      start = 1'b1;
      k_len = 8'd0;
      tick();
      start = 1'b0;
      chk("t3_busy", busy, 1'b0);
      chk("t3_in_ready", in_ready, 1'b0);
      sync_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (counter_sync_out || busy) sync_cnt++;
      end
      chk("t3_no_activity", sync_cnt, 0);

      // Tile k_len=3, second start with k_len=9 during STREAM
      set_beat(5);
      in_valid = 1'b1;
      start    = 1'b1;
      k_len    = 8'd3;
      tick();
      accepted = 0;
      v0_cnt   = 0;
      sync_cnt = 0;
      for (int c = 0; c < 14; c++) begin
         if (c == 0) begin
            start = 1'b1;
            k_len = 8'd9;
         end else begin
            start = 1'b0;
         end
         if (in_ready && in_valid) accepted++;
         tick();
         if (act_valid[0]) v0_cnt++;
         if (counter_sync_out) sync_cnt++;
      end
      chk("t4_accepted", accepted, 3);
      chk("t4_lane0_beats", v0_cnt, 3);
      chk("t4_sync_pulses", sync_cnt, 1);
      chk("t4_idle", busy, 1'b0);

      // Reset midway through DRAIN aborts the tile
      start = 1'b1;
      k_len = 8'd2;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("t5_in_drain", in_ready, 1'b0);
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("t5_act_valid", act_valid, 8'h00);
      chk("t5_wgt_valid", wgt_valid, 8'h00);
      chk("t5_busy", busy, 1'b0);
      chk("t5_in_ready", in_ready, 1'b0);
      sync_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (counter_sync_out) sync_cnt++;
      end
      chk("t5_no_sync", sync_cnt, 0);

      // Back-to-back tiles
      in_valid = 1'b1;
      set_beat(10);
      start = 1'b1;
      k_len = 8'd1;
      tick();
      start = 1'b0;
      tick();
      wait_sync(20, n_wait);
      chk("t6_first_sync", n_wait, 8);
      tick();
      start = 1'b1;
      k_len = 8'd2;
      set_beat(11);
      tick();
      start = 1'b0;
      chk("t6_second_busy", busy, 1'b1);
      tick();
      set_beat(12);
      tick();
      in_valid = 1'b0;
      exp_act = '0;
      exp_act[0] = 8'hC0;
      exp_act[1] = 8'hB1;
      chk("t6_e2_act", act_data, exp_act);
      chk("t6_e2_valid", act_valid, 8'h03);
      for (int c = 0; c < 6; c++) tick();
      exp_act = '0;
      exp_act[6] = 8'hC6;
      exp_act[7] = 8'hB7;
      chk("t6_e8_act", act_data, exp_act);
      chk("t6_e8_valid", act_valid, 8'hC0);
      chk("t6_e8_wgt", wgt_data, exp_act);
      wait_sync(20, n_wait);
      chk("t6_second_sync", n_wait, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mac_feeder.md
MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001: Parameters: DATA_W default 8, operand width; ROWS default 8, array rows; COLS default 8, array columns; KLEN_W default 8, beat-count width.
REQ-002: clk  input  1  sole clock, all state updates on rising edge.
REQ-003: reset_n  input  1  reset, synchronous and active-low.
REQ-004: start  input  1  one-cycle tile start request.
REQ-005: k_len  input  KLEN_W  beats in tile, sampled with accepted start.
REQ-006: in_valid  input  1  input beat valid.
REQ-007: in_ready  output  1  feeder accepts beat this cycle.
REQ-008: in_act  input  ROWS x DATA_W signed  one activation per row.
REQ-009: in_wgt  input  COLS x DATA_W signed  one weight per column.
REQ-010: act_data / act_valid  output  ROWS x DATA_W signed / ROWS x 1  skewed activations to array left edge.
REQ-011: wgt_data / wgt_valid  output  COLS x DATA_W signed / COLS x 1  skewed weights to array top edge.
REQ-012: counter_sync_out  output  1  one-cycle pulse to array counter_sync_in at tile end.
REQ-013: busy  output  1  high in any state other than IDLE.

Function
REQ-014: FSM states IDLE, STREAM, DRAIN, SYNC.
REQ-015: IDLE->STREAM when start=1 and k_len!=0; latch k_len, clear beat counter; start with k_len=0 ignored.
REQ-016: start while busy ignored, no effect on latched k_len.
REQ-017: in_ready = 1 only in STREAM; beat accepted when in_valid & in_ready.
REQ-018: Beat counter increments per accepted beat; STREAM->DRAIN in cycle the k_len-th beat accepted.
REQ-019: In STREAM with in_valid=0, a bubble (valid 0, data 0) enters every skew lane; beat counter holds.
REQ-020: Row lane i delays data+valid by 1+i cycles; column lane j delays by 1+j cycles.
REQ-021: Output data forced to 0 whenever corresponding valid is 0.
REQ-022: DRAIN lasts exactly max(ROWS,COLS) cycles, injecting bubbles, then ->SYNC.
REQ-023: SYNC lasts one cycle, counter_sync_out=1, then ->IDLE.
REQ-024: Beat data passed unmodified (no arithmetic, no width change).
REQ-025: All outputs registered; no combinational path from inputs to outputs except in_ready from state.

Reset
REQ-026: reset_n=0 at a rising edge: FSM->IDLE, all skew registers, valids, counters, latched k_len cleared to 0.
REQ-027: Outputs during/after reset: in_ready 0, busy 0, counter_sync_out 0, all act/wgt data and valid 0.
REQ-028: Reset mid-tile aborts tile; in-flight beats discarded, no sync pulse emitted.

Configuration
REQ-029: Macro MAC_FEEDER_STALL_CNT_EN defined: extra output stall_cnt 16 bits, counts STREAM cycles with in_valid=0, cleared on tile start and reset, saturates at 0xFFFF.
REQ-030: Macro undefined: stall_cnt port and counter absent; all other behaviour identical.

Verification
REQ-031: ROWS=COLS=8, start k_len=1, in_act[i]=i+1, in_wgt[j]=10+j, in_valid held -> act_data[3]=4 valid exactly at cycle 4 after acceptance, wgt_data[7]=17 at cycle 8; counter_sync_out at cycle 1+1+8+1 after start.
REQ-032: k_len=4, in_valid pattern 1,0,1,1,1 -> 4 beats accepted, bubble appears on every lane between beats 1 and 2, DRAIN entered after 5th STREAM cycle; stall_cnt=1 when macro defined.
REQ-033: start with k_len=0 -> busy stays 0, in_ready stays 0, no sync pulse.
REQ-034: start pulsed again during STREAM with k_len=9 (tile k_len=3) -> exactly 3 beats accepted, ignored start has no effect.
REQ-035: reset_n=0 for one cycle midway through DRAIN -> next cycle all valids 0, busy 0, no counter_sync_out pulse afterward.
REQ-036: Back-to-back tiles: start asserted in cycle after SYNC -> second tile accepted, lanes from both tiles never overlap valid with wrong data.
